// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions for the instruction sequencer: state encodings,
// opcode constants and the memory wait-counter width helper.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM      = 3'd4,
    ST_HALT     = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_BRN = 4'hD;
  localparam logic [3:0] OP_BRZ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  // Bits needed to hold 0..timeout in the memory wait counter.
  function automatic int wait_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/instr_sequencer_retire_counter.sv
// 16-bit retired-instruction counter: increments on enable, wraps at 0xFFFF.
module retire_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);

  // Count enabled cycles; natural 16-bit wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (en) begin
      count <= count + 16'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch/decode/execute control FSM with memory
// timeout fault, halt/resume and a retired-instruction counter.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_ack,
  input  logic [15:0] instr,
  input  logic        N,
  input  logic        Z,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_step,
  output logic        PL,
  output logic        JB,
  output logic        BC,
  output logic        rf_we,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  localparam int WAIT_W = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state_r;
  state_t              state_nx;
  logic [15:0]         ir_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [3:0]          op_s;
  logic                timeout_s;
  logic                unused_ir_s;

  assign op_s      = ir_r[15:12];
  assign timeout_s = (wait_cnt_r == WAIT_LAST) && !mem_ack;
  assign state     = state_r;
  // Operand field is consumed by the datapath, not by the sequencer.
  assign unused_ir_s = ^ir_r[11:0];

  // Output decode and next-state selection from current state, IR, flags and ack.
  always_comb begin
    state_nx = state_r;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    pc_step  = 1'b0;
    PL       = 1'b0;
    JB       = 1'b0;
    BC       = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state_r)
      ST_RST_WAIT: state_nx = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load  = 1'b1;
          state_nx = ST_DECODE;
        end else if (timeout_s) begin
          state_nx = ST_FAULT;
        end else begin
          state_nx = ST_FETCH;
        end
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        case (op_s)
          OP_NOP: begin
            pc_step  = 1'b1;
            state_nx = ST_FETCH;
          end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            rf_we    = 1'b1;
            pc_step  = 1'b1;
            state_nx = ST_FETCH;
          end
          OP_LD, OP_ST: state_nx = ST_MEM;
          OP_JMP: begin
            pc_step  = 1'b1;
            PL       = 1'b1;
            JB       = 1'b1;
            state_nx = ST_FETCH;
          end
          OP_BRN: begin
            pc_step  = 1'b1;
            PL       = N;
            state_nx = ST_FETCH;
          end
          OP_BRZ: begin
            pc_step  = 1'b1;
            BC       = 1'b1;
            PL       = Z;
            state_nx = ST_FETCH;
          end
          OP_HLT:  state_nx = ST_HALT;
          default: state_nx = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_s == OP_ST);
        if (mem_ack) begin
          rf_we    = (op_s == OP_LD);
          pc_step  = 1'b1;
          state_nx = ST_FETCH;
        end else if (timeout_s) begin
          state_nx = ST_FAULT;
        end else begin
          state_nx = ST_MEM;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          pc_step  = 1'b1;
          state_nx = ST_FETCH;
        end else begin
          state_nx = ST_HALT;
        end
      end
      ST_FAULT: fault = 1'b1;
      default:  state_nx = ST_FAULT;
    endcase
  end

  // State, instruction register and memory wait counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RST_WAIT;
      ir_r       <= 16'd0;
      wait_cnt_r <= '0;
    end else begin
      state_r <= state_nx;
      if (ir_load) begin
        ir_r <= instr;
      end else begin
        ir_r <= ir_r;
      end
      // Counter restarts on every state change, so entry to FETCH/MEM sees zero.
      if ((state_nx == state_r) && ((state_r == ST_FETCH) || (state_r == ST_MEM))) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  retire_counter u_retire_counter (
    .clock (clock),
    .reset (reset),
    .en    (pc_step),
    .count (retired)
  );

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ack before a fault; legal range 1..255.
REQ-002 Port clock  input  1  CPU clock; all state changes on the rising edge.
REQ-003 Port reset  input  1  CPU reset; asynchronous, active-low.
REQ-004 Port mem_ack  input  1  memory completion for the current mem_req cycle.
REQ-005 Port instr  input  16  instruction word from memory; valid only while mem_ack=1 in FETCH.
REQ-006 Port N, Z  input  1 each  negative and zero status flags from the datapath.
REQ-007 Port run  input  1  resume pulse; honoured only in HALT.
REQ-008 Port mem_req, mem_we  output  1 each  memory access request and write qualifier.
REQ-009 Port ir_load  output  1  instruction-register load strobe.
REQ-010 Port pc_step  output  1  one-cycle PC update strobe; the PC controller updates only on this strobe.
REQ-011 Port PL, JB, BC  output  1 each  PC load, jump/branch select and branch condition, to the PC controller.
REQ-012 Port rf_we  output  1  register-file write enable.
REQ-013 Port halted, fault  output  1 each  HALT / FAULT state indicators.
REQ-014 Port state  output  3  encoded current state, for debug.
REQ-015 Port retired  output  16  count of retired instructions.

Function
REQ-016 States SHALL be: RST_WAIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5, FAULT=6; all outputs registered-state driven, combinational decode only from state, IR, N, Z, mem_ack.
REQ-017 RST_WAIT SHALL drive all outputs 0 and SHALL go to FETCH on the next edge.
REQ-018 FETCH SHALL hold mem_req=1, mem_we=0; on mem_ack=1: ir_load=1, IR<=instr, go to DECODE in the same cycle.
REQ-019 DECODE SHALL last exactly one cycle, assert no strobes, then go to EXEC.
REQ-020 Opcode = IR[15:12]: 0x0 NOP; 0x1-0x7 ALU; 0x8 LD; 0x9 ST; 0xC JMP; 0xD BRN; 0xE BRZ; 0xF HLT; 0xA, 0xB illegal.
REQ-021 EXEC, NOP: pc_step=1, go to FETCH.
REQ-022 EXEC, ALU: rf_we=1, pc_step=1, go to FETCH.
REQ-023 EXEC, LD/ST: go to MEM.
REQ-024 MEM SHALL hold mem_req=1 with mem_we=1 for ST, 0 for LD; on mem_ack: rf_we=1 (LD only), pc_step=1, go to FETCH.
REQ-025 EXEC, JMP: pc_step=1, PL=1, JB=1, go to FETCH.
REQ-026 EXEC, BRN/BRZ: pc_step=1, JB=0, BC=0 for BRN and 1 for BRZ, PL=N for BRN and Z for BRZ, go to FETCH.
REQ-027 EXEC, HLT: go to HALT with no pc_step; HALT SHALL assert halted=1; run=1 SHALL give pc_step=1 and go to FETCH; run is ignored in every other state.
REQ-028 EXEC, illegal opcode: go to FAULT; FAULT SHALL assert fault=1 and hold until reset.
REQ-029 The wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without ack; reaching MEM_TIMEOUT with mem_ack=0 SHALL go to FAULT with no strobes.
REQ-030 mem_ack on the timeout cycle SHALL win: the access completes normally.
REQ-031 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-032 retired SHALL increment by 1 on every pc_step cycle and SHALL wrap from 0xFFFF to 0x0000.
REQ-033 PL, JB and BC SHALL be 0 whenever pc_step=0.

Reset
REQ-034 reset=0 SHALL immediately force state=RST_WAIT, IR=0, wait counter=0, retired=0, and all outputs 0, independent of clock, including mid-access.
REQ-035 The first mem_req SHALL occur in the second cycle after reset deasserts.

Structure
REQ-036 State encodings, opcode constants, and the timeout-counter width ($clog2(MEM_TIMEOUT+1)) SHALL reside in the shared CPU package.
REQ-037 The retired counter SHALL be a single sub-module, retire_counter (16-bit enable/wrap).

Verification
REQ-038 Reset release, instr=0x1234 with ack on the first request -> FETCH, DECODE, EXEC; rf_we=1, pc_step=1, retired=1 at the end of cycle 4.
REQ-039 BRZ (0xE005) with Z=1 then Z=0 -> PL=1/BC=1/JB=0, then PL=0; both cases pc_step=1.
REQ-040 LD 0x8xxx with ack delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, single rf_we pulse.
REQ-041 MEM_TIMEOUT=4, no ack in FETCH -> fault=1 after 4 cycles; ack on cycle 4 instead -> normal DECODE.
REQ-042 HLT (0xF000), run pulse after 10 cycles -> halted=1 for 10 cycles, then pc_step=1, FETCH; run in FETCH has no effect.
REQ-043 reset=0 asynchronously during MEM for ST -> mem_req/mem_we drop before the next edge; retired=0.
